// File: rtl/rv32i_types.sv
// Shared RV32I types used by the fetch-side cache.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RESP
  } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Flop-based storage for the instruction cache: valid bits, tags and line data,
// with a combinational read port, a word write port, a tag/valid write and a global invalidate.
module icache_array
  import rv32i_types::*;
#(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(NUM_SETS)-1:0]   rd_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_ofs,
  output logic                          rd_valid,
  output logic [29-$clog2(NUM_SETS)-$clog2(LINE_WORDS):0] rd_tag,
  output rv32i_word                     rd_word,
  input  logic                          word_we,
  input  logic [$clog2(NUM_SETS)-1:0]   wr_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_ofs,
  input  rv32i_word                     wr_word,
  input  logic                          tag_we,
  input  logic [29-$clog2(NUM_SETS)-$clog2(LINE_WORDS):0] wr_tag,
  input  logic                          wr_valid,
  input  logic                          invalidate
);

  localparam int OFS = $clog2(LINE_WORDS);
  localparam int IDX = $clog2(NUM_SETS);
  localparam int TAG = 30 - OFS - IDX;

  logic [NUM_SETS-1:0] valid;
  logic [TAG-1:0]      tags  [NUM_SETS];
  rv32i_word           words [NUM_SETS*LINE_WORDS];

  // A tag write in the same cycle as an invalidate takes wr_valid as final; the
  // owner drives wr_valid low whenever a flush is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (invalidate) valid <= '0;
      if (tag_we) valid[wr_idx] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (word_we) words[{wr_idx, wr_ofs}] <= wr_word;
    if (tag_we)  tags[wr_idx] <= wr_tag;
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_word  = words[{rd_idx, rd_ofs}];

endmodule

// File: rtl/icache_responder.sv
// Read-only direct-mapped instruction cache: answers IF-stage fetches and refills
// whole lines from physical memory with a burst read on a miss.
module icache_responder
  import rv32i_types::*;
#(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        imem_read_i,
  input  rv32i_word   imem_addr_i,
  input  logic        imem_write_i,
  input  rv32i_word   imem_wdata_i,
  input  logic [3:0]  imem_byte_en_i,
  output logic        imem_resp_o,
  output rv32i_word   imem_rdata_o,
  input  logic        flush_i,
  output logic        pmem_read_o,
  output rv32i_word   pmem_addr_o,
  input  logic        pmem_resp_i,
  input  rv32i_word   pmem_rdata_i
);

  localparam int OFS = $clog2(LINE_WORDS);
  localparam int IDX = $clog2(NUM_SETS);
  localparam int TAG = 30 - OFS - IDX;

  icache_state_t state, next_state;

  logic [IDX-1:0] idx_q;
  logic [TAG-1:0] tag_q;
  logic [OFS-1:0] ofs_q;
  logic [OFS-1:0] beat_q;
  logic           flushed_q;
  rv32i_word      rdata_q;

  logic [OFS-1:0] req_ofs;
  logic [IDX-1:0] req_idx;
  logic [TAG-1:0] req_tag;
  logic [IDX-1:0] lookup_idx;
  logic [OFS-1:0] lookup_ofs;
  logic           rd_valid;
  logic [TAG-1:0] rd_tag;
  rv32i_word      rd_word;
  logic           hit;
  logic           word_we;
  logic           tag_we;
  logic           fill_valid;
  logic           unused_inputs;

  assign req_ofs = imem_addr_i[OFS+1:2];
  assign req_idx = imem_addr_i[OFS+IDX+1:OFS+2];
  assign req_tag = imem_addr_i[31:OFS+IDX+2];

  assign unused_inputs = ^{imem_addr_i[1:0], imem_wdata_i, imem_byte_en_i, imem_write_i};

  assign hit          = rd_valid && (rd_tag == req_tag);
  assign fill_valid   = !(flushed_q || flush_i);
  assign imem_rdata_o = rdata_q;

  icache_array #(
    .NUM_SETS  (NUM_SETS),
    .LINE_WORDS(LINE_WORDS)
  ) u_array (
    .clk       (clk_i),
    .rst       (rst_i),
    .rd_idx    (lookup_idx),
    .rd_ofs    (lookup_ofs),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_word   (rd_word),
    .word_we   (word_we),
    .wr_idx    (idx_q),
    .wr_ofs    (beat_q),
    .wr_word   (pmem_rdata_i),
    .tag_we    (tag_we),
    .wr_tag    (tag_q),
    .wr_valid  (fill_valid),
    .invalidate(flush_i)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  // During FILL the read port points at the latched miss so the requested word
  // can be picked up from an earlier beat when the last beat lands.
  always_comb begin
    next_state  = state;
    lookup_idx  = req_idx;
    lookup_ofs  = req_ofs;
    word_we     = 1'b0;
    tag_we      = 1'b0;
    imem_resp_o = 1'b0;
    pmem_read_o = 1'b0;
    pmem_addr_o = '0;
    case (state)
      IDLE: begin
        if (imem_read_i) next_state = hit ? RESP : FILL;
      end
      FILL: begin
        lookup_idx  = idx_q;
        lookup_ofs  = ofs_q;
        pmem_read_o = 1'b1;
        pmem_addr_o = {tag_q, idx_q, {(OFS+2){1'b0}}};
        if (pmem_resp_i) begin
          word_we = 1'b1;
          if (beat_q == '1) begin
            tag_we     = 1'b1;
            next_state = RESP;
          end
        end
      end
      RESP: begin
        imem_resp_o = 1'b1;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q     <= '0;
      tag_q     <= '0;
      ofs_q     <= '0;
      beat_q    <= '0;
      flushed_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (imem_read_i) begin
            if (hit) begin
              rdata_q <= rd_word;
            end else begin
              idx_q     <= req_idx;
              tag_q     <= req_tag;
              ofs_q     <= req_ofs;
              beat_q    <= '0;
              flushed_q <= 1'b0;
            end
          end
        end
        FILL: begin
          if (flush_i) flushed_q <= 1'b1;
          if (pmem_resp_i) begin
            beat_q <= beat_q + 1'b1;
            // The last word of the line is only on the bus, not yet in storage.
            if (beat_q == '1) rdata_q <= (ofs_q == '1) ? pmem_rdata_i : rd_word;
          end
        end
        default: ;
      endcase
    end
  end

  no_write_request: assert property (@(posedge clk_i) disable iff (rst_i)
    !(imem_read_i && imem_write_i));

endmodule
